// File: rtl/avalon_burst_slave.sv
// Avalon-MM burst slave over a word memory, with a compute CSR (start/busy/done) at address 0.
// Write resp at T+1, read data at T+2 (decode errors at T+1); only IDLE/BWR/BERR_W drop waitrequest.
module avalon_burst_slave #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int BURST_W  = 10,
    parameter int MAX_ADDR = 1580
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic               write,
    input  logic               beginbursttransfer,
    input  logic [BURST_W-1:0] burstcount,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  writedata,
    output logic               waitrequest,
    output logic [DATA_W-1:0]  readdata,
    output logic               readdatavalid,
    output logic               writeresponsevalid,
    output logic [1:0]         response,
    output logic               mem_we,
    output logic               mem_re,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               start_calc,
    input  logic               done_calc
);
    localparam int SUM_W = ((ADDR_W > BURST_W) ? ADDR_W : BURST_W) + 1;
    localparam logic [SUM_W-1:0] MAX_W = SUM_W'(MAX_ADDR);
    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, WR_RESP, RD_ISSUE, RD_RESP, BWR, BRD, BERR_W, BERR_R
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  addr_q, beat_addr;
    logic [DATA_W-1:0]  wdata_q;
    logic [BURST_W-1:0] rem;
    logic [1:0]         resp_q, resp_idle;
    logic               csr_q, start_q, busy, done, wr_pend, rd_pend;

    logic [SUM_W-1:0] addr_ext, end_ext;
    logic addr_nz, single_ok, burst_ok, is_csr, csr_wr, csr_start, rem_last;

    // Range arithmetic is one bit wider than the address so address+count cannot wrap.
    assign addr_ext  = SUM_W'(address);
    assign end_ext   = addr_ext + SUM_W'(burstcount);
    assign addr_nz   = address != '0;
    assign single_ok = addr_nz && (addr_ext < MAX_W);
    assign burst_ok  = addr_nz && (burstcount != '0) && (end_ext <= MAX_W);
    assign is_csr    = !addr_nz && !beginbursttransfer;
    assign csr_wr    = (state == IDLE) && write && !read && is_csr;
    assign csr_start = csr_wr && writedata[0] && !busy;
    assign rem_last  = rem == BURST_W'(1);

    always_comb begin
        resp_idle = RESP_OK;
        if (read && write) begin
            resp_idle = RESP_DECERR;
        end else if (beginbursttransfer) begin
            resp_idle = burst_ok ? RESP_OK : RESP_DECERR;
        end else if (is_csr) begin
            resp_idle = (write && writedata[0] && busy) ? RESP_SLVERR : RESP_OK;
        end else begin
            resp_idle = single_ok ? RESP_OK : RESP_DECERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        waitrequest        = 1'b1;
        readdata           = '0;
        readdatavalid      = 1'b0;
        writeresponsevalid = 1'b0;
        response           = RESP_OK;
        mem_we             = 1'b0;
        mem_re             = 1'b0;
        mem_addr           = '0;
        mem_wdata          = '0;
        start_calc         = 1'b0;
        case (state)
            IDLE: begin
                waitrequest = 1'b0;
                if (read && write) begin
                    state_nxt = WR_RESP;
                end else if (write) begin
                    if (!beginbursttransfer || burstcount <= BURST_W'(1)) begin
                        state_nxt = WR_RESP;
                    end else begin
                        state_nxt = burst_ok ? BWR : BERR_W;
                    end
                end else if (read) begin
                    if (beginbursttransfer) begin
                        if (!burst_ok) begin
                            state_nxt = BERR_R;
                        end else begin
                            state_nxt = (burstcount == BURST_W'(1)) ? RD_ISSUE : BRD;
                        end
                    end else begin
                        state_nxt = (single_ok || is_csr) ? RD_ISSUE : RD_RESP;
                    end
                end
            end
            WR_RESP: begin
                writeresponsevalid = 1'b1;
                response           = resp_q;
                mem_we             = !csr_q && (resp_q == RESP_OK);
                mem_addr           = addr_q;
                mem_wdata          = wdata_q;
                start_calc         = start_q;
                state_nxt          = IDLE;
            end
            RD_ISSUE: begin
                mem_re    = !csr_q;
                mem_addr  = addr_q;
                state_nxt = RD_RESP;
            end
            RD_RESP: begin
                readdatavalid = 1'b1;
                response      = resp_q;
                if (resp_q == RESP_OK) begin
                    readdata = csr_q ? DATA_W'({done, busy}) : mem_rdata;
                end
                state_nxt = IDLE;
            end
            BWR, BERR_W: begin
                waitrequest = 1'b0;
                mem_we      = (state == BWR) && wr_pend;
                mem_addr    = addr_q;
                mem_wdata   = wdata_q;
                if (write && rem_last) begin
                    state_nxt = WR_RESP;
                end
            end
            BRD: begin
                mem_re        = 1'b1;
                mem_addr      = addr_q;
                readdatavalid = rd_pend;
                readdata      = rd_pend ? mem_rdata : '0;
                if (rem_last) begin
                    state_nxt = RD_RESP;
                end
            end
            BERR_R: begin
                readdatavalid = 1'b1;
                response      = RESP_DECERR;
                if (rem_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            beat_addr <= '0;
            wdata_q   <= '0;
            rem       <= '0;
            resp_q    <= RESP_OK;
            csr_q     <= 1'b0;
            start_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            // A done pulse coinciding with a CSR clear leaves done set.
            if (done_calc) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (csr_start) begin
                busy <= 1'b1;
            end
            if (csr_wr && writedata[1] && !done_calc) begin
                done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    start_q   <= csr_start;
                    wr_pend   <= 1'b1;
                    rd_pend   <= 1'b0;
                    csr_q     <= is_csr && !(read && write);
                    resp_q    <= resp_idle;
                    addr_q    <= address;
                    wdata_q   <= writedata;
                    beat_addr <= address + ADDR_W'(1);
                    if (write) begin
                        rem <= burstcount - BURST_W'(1);
                    end else begin
                        rem <= (burstcount == '0) ? BURST_W'(1) : burstcount;
                    end
                end
                BWR, BERR_W: begin
                    wr_pend <= write;
                    if (write) begin
                        addr_q    <= beat_addr;
                        wdata_q   <= writedata;
                        beat_addr <= beat_addr + ADDR_W'(1);
                        rem       <= rem - BURST_W'(1);
                    end
                end
                BRD: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    rem     <= rem - BURST_W'(1);
                    rd_pend <= 1'b1;
                end
                BERR_R: begin
                    rem <= rem - BURST_W'(1);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_burst_slave.sv
module tb_avalon_burst_slave;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 11;
    localparam int BURST_W = 10;

    // Status vector: {waitrequest, writeresponsevalid, readdatavalid, response[1:0], mem_we, mem_re}
    localparam logic [6:0] S_IDLE = 7'b0000000;
    localparam logic [6:0] S_WOK  = 7'b1100010;
    localparam logic [6:0] S_WERR = 7'b1101100;
    localparam logic [6:0] S_WCSR = 7'b1100000;
    localparam logic [6:0] S_WSLV = 7'b1101000;
    localparam logic [6:0] S_RISS = 7'b1000001;
    localparam logic [6:0] S_RCSR = 7'b1000000;
    localparam logic [6:0] S_ROK  = 7'b1010000;
    localparam logic [6:0] S_RERR = 7'b1011100;
    localparam logic [6:0] S_BWE  = 7'b0000010;
    localparam logic [6:0] S_BRD0 = 7'b1000001;
    localparam logic [6:0] S_BRDV = 7'b1010001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic read, write, bbt, readdatavalid, writeresponsevalid, waitrequest;
    logic mem_we, mem_re, start_calc, done_calc;
    logic [BURST_W-1:0] burstcount;
    logic [ADDR_W-1:0]  address, mem_addr;
    logic [DATA_W-1:0]  writedata, readdata, mem_wdata;
    logic [DATA_W-1:0]  mem_rdata = '0;
    logic [1:0]         response;
    logic [6:0]         st;
    logic [DATA_W-1:0]  mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]  bd [0:3];
    int checks = 0;
    int failures = 0;
    int we_cnt = 0, re_cnt = 0, rdv_cnt = 0, wrv_cnt = 0;

    assign st = {waitrequest, writeresponsevalid, readdatavalid, response, mem_we, mem_re};

    avalon_burst_slave dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .beginbursttransfer(bbt),
        .burstcount(burstcount), .address(address), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .writeresponsevalid(writeresponsevalid), .response(response),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .start_calc(start_calc), .done_calc(done_calc)
    );

    always #5 clk = ~clk;

    // Backing memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_cnt <= re_cnt + 1;
        end
        if (readdatavalid) rdv_cnt <= rdv_cnt + 1;
        if (writeresponsevalid) wrv_cnt <= wrv_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read = 0; write = 0; bbt = 0; burstcount = '0; address = '0; writedata = '0;
    endtask

    task automatic test_reset();
        idle(); done_calc = 0; rst = 1;
        tick(); tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL rst_status got=%b exp=%b", st, S_IDLE); end
        checks++; if ({readdata, start_calc, mem_addr} !== '0) begin failures++; $display("FAIL rst_data got=%h/%b/%h exp=0", readdata, start_calc, mem_addr); end
        rst = 0; tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL rst_release got=%b exp=%b", st, S_IDLE); end
    endtask

    task automatic test_single();
        write = 1; address = 11'h010; writedata = 32'hDEADBEEF;
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL sw_accept got=%b exp=%b", st, S_IDLE); end
        tick(); idle();
        checks++; if (st !== S_WOK) begin failures++; $display("FAIL sw_t1 got=%b exp=%b", st, S_WOK); end
        checks++; if ({mem_addr, mem_wdata} !== {11'h010, 32'hDEADBEEF}) begin failures++; $display("FAIL sw_addr_data got=%h/%h exp=010/deadbeef", mem_addr, mem_wdata); end
        tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL sw_t2 got=%b exp=%b", st, S_IDLE); end
        read = 1; address = 11'h010;
        tick(); idle();
        checks++; if (st !== S_RISS || mem_addr !== 11'h010) begin failures++; $display("FAIL sr_t1 got=%b/%h exp=%b/010", st, mem_addr, S_RISS); end
        tick();
        checks++; if (st !== S_ROK) begin failures++; $display("FAIL sr_t2 got=%b exp=%b", st, S_ROK); end
        checks++; if (readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_data got=%h exp=deadbeef", readdata); end
        tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL sr_t3 got=%b exp=%b", st, S_IDLE); end
        write = 1; address = 11'h62B; writedata = 32'h12345678;
        tick(); idle();
        checks++; if (st !== S_WOK || mem_addr !== 11'h62B) begin failures++; $display("FAIL sw_top got=%b/%h exp=%b/62b", st, mem_addr, S_WOK); end
        tick();
    endtask

    task automatic test_invalid();
        int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        read = 1; address = 11'h62C;
        tick(); idle();
        checks++; if (st !== S_RERR || readdata !== '0) begin failures++; $display("FAIL inv_rd got=%b/%h exp=%b/0", st, readdata, S_RERR); end
        tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL inv_rd_done got=%b exp=%b", st, S_IDLE); end
        write = 1; address = 11'h62C; writedata = 32'h5;
        tick(); idle();
        checks++; if (st !== S_WERR) begin failures++; $display("FAIL inv_wr got=%b exp=%b", st, S_WERR); end
        tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL inv_wr_done got=%b exp=%b", st, S_IDLE); end
        read = 1; write = 1; address = 11'h020;
        tick(); idle();
        checks++; if (st !== S_WERR) begin failures++; $display("FAIL rw_both got=%b exp=%b", st, S_WERR); end
        tick();
        checks++; if (we_cnt != we0 || re_cnt != re0) begin failures++; $display("FAIL inv_no_mem got=%0d/%0d exp=%0d/%0d", we_cnt, re_cnt, we0, re0); end
    endtask

    task automatic test_burst();
        int w0;
        w0 = wrv_cnt;
        write = 1; bbt = 1; burstcount = 10'd4; address = 11'h100; writedata = bd[0];
        tick();
        bbt = 0; burstcount = '0; address = '0; writedata = bd[1];
        checks++; if (st !== S_BWE || {mem_addr, mem_wdata} !== {11'h100, bd[0]}) begin failures++; $display("FAIL bw_b0 got=%b/%h/%h exp=%b/100/%h", st, mem_addr, mem_wdata, S_BWE, bd[0]); end
        tick(); writedata = bd[2];
        checks++; if (st !== S_BWE || {mem_addr, mem_wdata} !== {11'h101, bd[1]}) begin failures++; $display("FAIL bw_b1 got=%b/%h/%h exp=%b/101/%h", st, mem_addr, mem_wdata, S_BWE, bd[1]); end
        tick(); write = 0;
        checks++; if (st !== S_BWE || {mem_addr, mem_wdata} !== {11'h102, bd[2]}) begin failures++; $display("FAIL bw_b2 got=%b/%h/%h exp=%b/102/%h", st, mem_addr, mem_wdata, S_BWE, bd[2]); end
        tick(); write = 1; writedata = bd[3];
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL bw_gap got=%b exp=%b", st, S_IDLE); end
        tick(); idle();
        checks++; if (st !== S_WOK || {mem_addr, mem_wdata} !== {11'h103, bd[3]}) begin failures++; $display("FAIL bw_last got=%b/%h/%h exp=%b/103/%h", st, mem_addr, mem_wdata, S_WOK, bd[3]); end
        tick();
        checks++; if (st !== S_IDLE || wrv_cnt - w0 != 1) begin failures++; $display("FAIL bw_resp_once got=%b/%0d exp=%b/1", st, wrv_cnt - w0, S_IDLE); end
        read = 1; bbt = 1; burstcount = 10'd4; address = 11'h100;
        tick(); idle();
        for (int c = 1; c <= 6; c++) begin
            logic [6:0] exp;
            exp = (c == 1) ? S_BRD0 : (c <= 4) ? S_BRDV : (c == 5) ? S_ROK : S_IDLE;
            checks++; if (st !== exp) begin failures++; $display("FAIL br_status c=%0d got=%b exp=%b", c, st, exp); end
            if (c <= 4) begin
                checks++; if (mem_addr !== ADDR_W'(256 + c - 1)) begin failures++; $display("FAIL br_addr c=%0d got=%h exp=%h", c, mem_addr, 256 + c - 1); end
            end
            if (c >= 2 && c <= 5) begin
                checks++; if (readdata !== bd[c-2]) begin failures++; $display("FAIL br_data c=%0d got=%h exp=%h", c, readdata, bd[c-2]); end
            end
            tick();
        end
    endtask

    task automatic test_burst_err();
        int we0;
        we0 = we_cnt;
        write = 1; bbt = 1; burstcount = 10'd3; address = 11'h62A; writedata = 32'hBAD0;
        tick(); bbt = 0;
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL bew_b1 got=%b exp=%b", st, S_IDLE); end
        tick();
        checks++; if (st !== S_IDLE) begin failures++; $display("FAIL bew_b2 got=%b exp=%b", st, S_IDLE); end
        tick(); idle();
        checks++; if (st !== S_WERR) begin failures++; $display("FAIL bew_resp got=%b exp=%b", st, S_WERR); end
        tick();
        checks++; if (st !== S_IDLE || we_cnt != we0) begin failures++; $display("FAIL bew_done got=%b/%0d exp=%b/%0d", st, we_cnt, S_IDLE, we0); end
        read = 1; bbt = 1; burstcount = 10'd3; address = 11'h62A;
        tick(); idle();
        for (int c = 1; c <= 4; c++) begin
            logic [6:0] exp;
            exp = (c <= 3) ? S_RERR : S_IDLE;
            checks++; if (st !== exp || readdata !== '0) begin failures++; $display("FAIL ber c=%0d got=%b/%h exp=%b/0", c, st, readdata, exp); end
            tick();
        end
        write = 1; bbt = 1; burstcount = '0; address = 11'h010;
        tick(); idle();
        checks++; if (st !== S_WERR) begin failures++; $display("FAIL bcnt0 got=%b exp=%b", st, S_WERR); end
        tick();
        write = 1; bbt = 1; burstcount = 10'd2; address = 11'h62A; writedata = 32'hE0;
        tick(); bbt = 0; burstcount = '0; writedata = 32'hE1;
        checks++; if (st !== S_BWE || mem_addr !== 11'h62A) begin failures++; $display("FAIL bedge_b0 got=%b/%h exp=%b/62a", st, mem_addr, S_BWE); end
        tick(); idle();
        checks++; if (st !== S_WOK || mem_addr !== 11'h62B) begin failures++; $display("FAIL bedge_b1 got=%b/%h exp=%b/62b", st, mem_addr, S_WOK); end
        tick();
    endtask

    task automatic test_csr();
        write = 1; address = '0; writedata = 32'h1;
        tick(); idle();
        checks++; if (st !== S_WCSR || start_calc !== 1'b1) begin failures++; $display("FAIL csr_start got=%b/%b exp=%b/1", st, start_calc, S_WCSR); end
        tick();
        checks++; if (st !== S_IDLE || start_calc !== 1'b0) begin failures++; $display("FAIL csr_pulse got=%b/%b exp=%b/0", st, start_calc, S_IDLE); end
        read = 1; address = '0;
        tick(); idle();
        checks++; if (st !== S_RCSR) begin failures++; $display("FAIL csr_rd_nore got=%b exp=%b", st, S_RCSR); end
        tick();
        checks++; if (st !== S_ROK || readdata !== 32'h1) begin failures++; $display("FAIL csr_busy got=%b/%h exp=%b/1", st, readdata, S_ROK); end
        tick();
        write = 1; address = '0; writedata = 32'h1;
        tick(); idle();
        checks++; if (st !== S_WSLV || start_calc !== 1'b0) begin failures++; $display("FAIL csr_slverr got=%b/%b exp=%b/0", st, start_calc, S_WSLV); end
        tick();
        done_calc = 1; tick(); done_calc = 0;
        read = 1; address = '0;
        tick(); idle(); tick();
        checks++; if (readdata !== 32'h2) begin failures++; $display("FAIL csr_done got=%h exp=2", readdata); end
        tick();
        write = 1; address = '0; writedata = 32'h2;
        tick(); idle();
        checks++; if (st !== S_WCSR) begin failures++; $display("FAIL csr_clr got=%b exp=%b", st, S_WCSR); end
        tick();
        read = 1; address = '0;
        tick(); idle(); tick();
        checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL csr_cleared got=%h exp=0", readdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int r0;
        r0 = rdv_cnt;
        read = 1; bbt = 1; burstcount = 10'd5; address = 11'h100;
        tick(); idle();
        tick();
        checks++; if (st !== S_BRDV || readdata !== bd[0]) begin failures++; $display("FAIL rm_b0 got=%b/%h exp=%b/%h", st, readdata, S_BRDV, bd[0]); end
        tick();
        checks++; if (st !== S_BRDV || readdata !== bd[1]) begin failures++; $display("FAIL rm_b1 got=%b/%h exp=%b/%h", st, readdata, S_BRDV, bd[1]); end
        rst = 1; tick(); rst = 0;
        checks++; if (st !== S_IDLE || readdata !== '0) begin failures++; $display("FAIL rm_cleared got=%b/%h exp=%b/0", st, readdata, S_IDLE); end
        tick(); tick(); tick();
        checks++; if (rdv_cnt - r0 != 2) begin failures++; $display("FAIL rm_no_more_rdv got=%0d exp=2", rdv_cnt - r0); end
        read = 1; address = 11'h101;
        tick(); idle(); tick();
        checks++; if (st !== S_ROK || readdata !== bd[1]) begin failures++; $display("FAIL rm_new_read got=%b/%h exp=%b/%h", st, readdata, S_ROK, bd[1]); end
        tick();
    endtask

    initial begin
        bd[0] = 32'hA5A5_0001; bd[1] = 32'h5A5A_0002; bd[2] = 32'hC3C3_0003; bd[3] = 32'h3C3C_0004;
        test_reset();
        test_single();
        test_invalid();
        test_burst();
        test_burst_err();
        test_csr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/avalon_burst_slave.md
Name: avalon_burst_slave

Overview:
Parametrised Avalon-MM slave controller for the accelerator's memory-mapped interface. It supports single and burst reads and writes into a backing word memory, with address-range checking and Avalon response codes. It also adds a control/status register at address 0 that starts the compute engine and reports busy/done. It sits between the host Avalon fabric and the on-chip sample memory plus calculation core.

Parameters:
DATA_W, 32, data word width
ADDR_W, 11, word address width
BURST_W, 10, burstcount width
MAX_ADDR, 1580 (0x62C), exclusive upper bound of memory window; valid memory addresses are 1..MAX_ADDR-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
read  in  1  Avalon read command
write  in  1  Avalon write command
beginbursttransfer  in  1  first beat of burst (with read or write)
burstcount  in  BURST_W  beats in burst, sampled with beginbursttransfer
address  in  ADDR_W  word address
writedata  in  DATA_W  write data
waitrequest  out  1  slave stall
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata/response valid
writeresponsevalid  out  1  write response valid
response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERROR
mem_we  out  1  backing memory write strobe
mem_re  out  1  backing memory read strobe
mem_addr  out  ADDR_W  backing memory address
mem_wdata  out  DATA_W  backing memory write data
mem_rdata  in  DATA_W  read data, valid one cycle after mem_re
start_calc  out  1  one-cycle compute start pulse
done_calc  in  1  compute finished pulse

Behaviour:
- Reset: state IDLE. All outputs are 0 except waitrequest=0. Beat counter, busy and done are 0. Reset mid-operation aborts immediately, with no pending response. Memory already written is not rolled back.
- States: IDLE, WR_RESP, RD_ISSUE, RD_RESP, BWR, BRD, BERR_W, BERR_R.
- waitrequest: 0 in IDLE and BWR/BERR_W; 1 in all other states. A command is accepted only in IDLE.
- Range check uses ADDR_W+1 bits so there is no wrap. A single access is valid iff 1 <= address < MAX_ADDR. A burst is valid iff address >= 1, burstcount >= 1 and address+burstcount <= MAX_ADDR. Address 0 is the CSR.
- read and write both high in IDLE: treated as an invalid write. writeresponsevalid=1 with response 11 next cycle, no memory access.
- Single write (accepted at T): mem_we=1 with registered address/data at T+1, plus writeresponsevalid=1 with response 00. Back to IDLE at T+2. An invalid address gives no mem_we and response 11 at T+1.
- Single read (T): mem_re at T+1. At T+2 readdata=mem_rdata, readdatavalid=1, response 00; IDLE at T+3. An invalid address gives readdatavalid at T+1 with readdata=0 and response 11.
- CSR write (address 0, single): if writedata[0]=1 and busy=0, start_calc pulses at T+1, busy is set, response 00. If writedata[0]=1 and busy=1, response 10 and no pulse. writedata[1]=1 clears done. The response timing matches a single write.
- CSR read returns {0..., done, busy} with single-read timing and no mem_re.
- done_calc: clears busy and sets done (sticky). If it coincides with a CSR clear, done wins.
- Burst write (first beat at T, count N): BWR accepts one beat per cycle while write=1; write=0 stalls. Beat k is written to address+k, with mem_we one cycle after acceptance. writeresponsevalid (00) comes once, in the cycle of the last mem_we.
- Invalid burst write goes to BERR_W. All N beats are consumed, no mem_we, single response 11 after the last beat.
- Burst read (T, N): mem_re for address+k at T+1+k, back-to-back. readdatavalid for beat k at T+2+k with response 00. Returns to IDLE after the last beat.
- Invalid burst read: N consecutive readdatavalid beats from T+1, readdata=0, response 11.
- beginbursttransfer with burstcount=0: decode error with a single response.

Test Plan:
- Reset then single write 0xDEADBEEF @0x010, then read @0x010 -> mem_we at T+1, readdatavalid at T+2 with 0xDEADBEEF and response 00.
- Single read @0x62C and write @0x62C -> response 11, no mem_re/mem_we, waitrequest low again 2 cycles later.
- Burst write N=4 @0x100 with a one-cycle write=0 gap after beat 2 -> mem_we to 0x100..0x103 in order, one writeresponsevalid (00) after the 4th beat; then burst read N=4 returns the same data on 4 consecutive readdatavalid cycles.
- Burst write @0x62A N=3 (ends at 0x62D > MAX) -> 3 beats consumed, no mem_we, one response 11.
- CSR write 0x1 -> start_calc pulse. A second write 0x1 before done_calc -> response 10 with no pulse. After done_calc, CSR read = 0x2. Write 0x2 then read = 0x0.
- Assert rst mid-burst-read after 2 of 5 beats -> outputs cleared next cycle, no further readdatavalid, a new single read then succeeds.
